// File: rtl/lc3b_types.sv
// LC-3b shared types: opcodes, MEM sequencer states, lane enables.
// Imported by the MEM-stage sequencer and its byte-lane helper.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IND,
    S_ACCESS,
    S_DONE
  } mas_state_t;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane helper: lane enables, STB replication, LDB sign extension.
// Ports: i_byte/i_addr0 select lane; i_store_data/i_rdata in; o_be/o_wdata/o_ldb out.
module mem_byte_lane
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_byte,
  input  logic             i_addr0,
  input  logic [WIDTH-1:0] i_store_data,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [1:0]       o_be,
  output logic [WIDTH-1:0] o_wdata,
  output logic [WIDTH-1:0] o_ldb
);

  logic [7:0] w_byte;

  assign o_be = !i_byte ? BE_WORD :
                (i_addr0 ? BE_HI : BE_LO);

  assign w_byte = i_addr0 ? i_rdata[15:8]
                          : i_rdata[7:0];

  assign o_ldb = {{(WIDTH-8){w_byte[7]}}, w_byte};

  // STB drives the byte on both lanes; be picks one
  assign o_wdata = i_byte ?
    {(WIDTH/8){i_store_data[7:0]}} : i_store_data;

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage sequencer: LDR/LDB/LDI/STR/STB/STI/TRAP data-memory accesses.
// Ports: EX/MEM control in, dmem request/response, stall, load_data, done.
module mem_access_sequencer
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [3:0]       opcode,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic [WIDTH-1:0] address_in,
  input  logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       dmem_byte_enable,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_resp,
  output logic             stall,
  output logic [WIDTH-1:0] load_data,
  output logic             done
);

  mas_state_t       r_state;
  lc3b_opcode       r_op;
  logic             r_mw;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_sd;
  logic [WIDTH-1:0] r_ptr;
  logic [WIDTH-1:0] r_load;
  logic             r_done;

  lc3b_opcode       w_op_in;
  logic             w_mem_op;
  logic             w_ind_in;
  logic             w_ind;
  logic             w_byte;
  logic             w_known;
  logic             w_wr;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_acc_addr;
  logic [1:0]       w_be;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_ldb;

  assign w_op_in  = lc3b_opcode'(opcode);
  assign w_ind_in = (w_op_in == op_ldi) ||
                    (w_op_in == op_sti);
  assign w_mem_op = valid_in &
    (mem_read_in | mem_write_in | w_ind_in |
     (w_op_in == op_trap));

  assign w_ind  = (r_op == op_ldi) || (r_op == op_sti);
  assign w_byte = (r_op == op_ldb) || (r_op == op_stb);
  assign w_known = w_ind || w_byte ||
                   (r_op == op_ldr) || (r_op == op_str) ||
                   (r_op == op_trap);
  // unknown opcodes fall back to the decoder's write flag
  assign w_wr = (r_op == op_str) || (r_op == op_stb) ||
                (r_op == op_sti) || (!w_known && r_mw);

  assign w_base     = w_ind ? r_ptr : r_addr;
  assign w_acc_addr = w_byte ? w_base
                             : {w_base[WIDTH-1:1], 1'b0};

  mem_byte_lane #(.WIDTH(WIDTH)) u_lane (
    .i_byte       (w_byte),
    .i_addr0      (w_acc_addr[0]),
    .i_store_data (r_sd),
    .i_rdata      (dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ldb        (w_ldb)
  );

  // requests decode from state only, so reset drops them at once
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_byte_enable = BE_NONE;
    dmem_wdata       = '0;
    stall            = 1'b0;
    unique case (r_state)
      S_IDLE: stall = w_mem_op;
      S_IND: begin
        dmem_read        = 1'b1;
        dmem_address     = {r_addr[WIDTH-1:1], 1'b0};
        dmem_byte_enable = BE_WORD;
        stall            = 1'b1;
      end
      S_ACCESS: begin
        dmem_read        = !w_wr;
        dmem_write       = w_wr;
        dmem_address     = w_acc_addr;
        dmem_byte_enable = w_be;
        dmem_wdata       = w_wr ? w_wdata : '0;
        stall            = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= op_br;
      r_mw    <= 1'b0;
      r_addr  <= '0;
      r_sd    <= '0;
      r_ptr   <= '0;
      r_load  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_op    <= w_op_in;
            r_mw    <= mem_write_in;
            r_addr  <= address_in;
            r_sd    <= store_data;
            r_state <= w_ind_in ? S_IND : S_ACCESS;
          end
        end
        S_IND: begin
          if (dmem_resp) begin
            r_ptr   <= dmem_rdata;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (dmem_resp) begin
            if (!w_wr)
              r_load <= w_byte ? w_ldb : dmem_rdata;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_data = r_load;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed cases plus random transactions
// against a transaction-level memory model and responder.
module tb_mem_access_sequencer;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_TRAP = 4'hF;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [3:0]  opcode;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [15:0] address_in;
  logic [15:0] store_data;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic        stall;
  logic [15:0] load_data;
  logic        done;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_load;

  always #5 clk = ~clk;

  mem_access_sequencer #(.WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_in         (valid_in),
    .opcode           (opcode),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .address_in       (address_in),
    .store_data       (store_data),
    .dmem_address     (dmem_address),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .stall            (stall),
    .load_data        (load_data),
    .done             (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // One instruction through MEM. Latencies count request
  // cycles including the dmem_resp cycle.
  task automatic run_txn(input logic [3:0] op,
                         input logic [15:0] addr,
                         input logic [15:0] sd,
                         input logic [15:0] r1,
                         input logic [15:0] r2,
                         input int l1,
                         input int l2,
                         input bit scramble);
    bit ind, byt, wr, fin;
    logic [15:0] ea[2];
    logic [1:0]  eb[2];
    bit          ew[2];
    logic [15:0] ed[2];
    logic [15:0] rv[2];
    int          lat[2];
    int nacc, acc, cnt, nstall;
    logic [15:0] base;
    logic [7:0]  bb;
    logic [15:0] f_addr;
    logic        f_rd, f_wr;
    ind = (op == OP_LDI) || (op == OP_STI);
    byt = (op == OP_LDB) || (op == OP_STB);
    wr  = (op == OP_STR) || (op == OP_STB) ||
          (op == OP_STI);
    nacc = 0;
    if (ind) begin
      ea[0]  = {addr[15:1], 1'b0};
      eb[0]  = 2'b11;
      ew[0]  = 1'b0;
      ed[0]  = 16'h0;
      lat[0] = l1;
      rv[0]  = r1;
      nacc   = 1;
    end
    base = ind ? r1 : addr;
    ea[nacc]  = byt ? base : {base[15:1], 1'b0};
    eb[nacc]  = !byt ? 2'b11 :
                (base[0] ? 2'b10 : 2'b01);
    ew[nacc]  = wr;
    ed[nacc]  = (op == OP_STB) ?
                {sd[7:0], sd[7:0]} : sd;
    lat[nacc] = l2;
    rv[nacc]  = r2;
    nacc++;
    if (!wr) begin
      bb = base[0] ? r2[15:8] : r2[7:0];
      exp_load = byt ? {{8{bb[7]}}, bb} : r2;
    end

    valid_in     = 1'b1;
    opcode       = op;
    mem_read_in  = (op == OP_LDR) || (op == OP_LDB) ||
                   (((op == OP_LDI) || (op == OP_TRAP)) &&
                    ($urandom_range(0, 1) == 1));
    mem_write_in = (op == OP_STR) || (op == OP_STB) ||
                   ((op == OP_STI) &&
                    ($urandom_range(0, 1) == 1));
    address_in   = addr;
    store_data   = sd;
    acc = 0; cnt = 0; nstall = 0; fin = 0;
    f_addr = '0; f_rd = 0; f_wr = 0;

    for (int c = 0; c < 400 && !fin; c++) begin
      #1;
      chk("rw_excl", {31'b0, dmem_read & dmem_write}, 0);
      if (stall) nstall++;
      if (done) begin
        fin = 1;
        chk("done_noreq", {dmem_read, dmem_write}, 0);
        chk("load_data", load_data, exp_load);
        valid_in = 1'b0;
      end else if (dmem_read | dmem_write) begin
        if (acc >= nacc) begin
          chk("extra_req", acc, nacc - 1);
          fin = 1;
        end else begin
          cnt++;
          if (cnt == 1) begin
            f_addr = dmem_address;
            f_rd   = dmem_read;
            f_wr   = dmem_write;
            chk("addr", dmem_address, ea[acc]);
            chk("rd", dmem_read, !ew[acc]);
            chk("wr", dmem_write, ew[acc]);
            chk("be", dmem_byte_enable, eb[acc]);
            if (ew[acc]) chk("wdata", dmem_wdata, ed[acc]);
          end else begin
            chk("hold", {dmem_read, dmem_write, dmem_address},
                {f_rd, f_wr, f_addr});
          end
          if (cnt == lat[acc]) begin
            dmem_resp  = 1'b1;
            dmem_rdata = rv[acc];
          end
        end
      end
      @(posedge clk);
      #1;
      if (dmem_resp) begin
        dmem_resp  = 1'b0;
        dmem_rdata = 16'($urandom);
        acc++;
        cnt = 0;
      end
      if (scramble && !fin) begin
        valid_in = 1'($urandom);
        opcode   = 4'($urandom);
      end
    end
    chk("finished", {31'b0, fin}, 1);
    chk("accesses", acc, nacc);
    chk("stall_cycles", nstall,
        1 + (ind ? l1 : 0) + l2);
    #1;
    chk("done_once", {31'b0, done}, 0);
    chk("idle_stall", {31'b0, stall}, 0);
    chk("idle_noreq", {dmem_read, dmem_write}, 0);
  endtask

  initial begin
    logic [3:0] ops[7];
    ops[0] = OP_LDR; ops[1] = OP_LDB; ops[2] = OP_LDI;
    ops[3] = OP_STR; ops[4] = OP_STB; ops[5] = OP_STI;
    ops[6] = OP_TRAP;

    reset = 1'b1;
    valid_in = 0; opcode = OP_ADD;
    mem_read_in = 0; mem_write_in = 0;
    address_in = 0; store_data = 0;
    dmem_rdata = 0; dmem_resp = 0;
    exp_load = 16'h0;
    #12;
    chk("rst_load", load_data, 16'h0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_req", {dmem_read, dmem_write}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn(OP_LDR, 16'h1003, 16'h0, 16'h0,
            16'hBEEF, 1, 2, 0);
    run_txn(OP_LDB, 16'h2001, 16'h0, 16'h0,
            16'h80FF, 1, 1, 0);
    run_txn(OP_LDB, 16'h2000, 16'h0, 16'h0,
            16'h80FF, 1, 3, 0);
    run_txn(OP_STB, 16'h3001, 16'h1234, 16'h0,
            16'h5555, 1, 2, 0);
    run_txn(OP_LDI, 16'h4000, 16'h0, 16'h5000,
            16'h00AA, 2, 2, 0);
    run_txn(OP_STI, 16'h4100, 16'hCAFE, 16'h6002,
            16'h0, 1, 1, 0);
    run_txn(OP_TRAP, 16'h0046, 16'h0, 16'h0,
            16'h3000, 2, 1, 0);

    // non-memory op stays idle; stray resp ignored
    valid_in = 1; opcode = OP_ADD;
    mem_read_in = 0; mem_write_in = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("nonmem_stall", {31'b0, stall}, 0);
      chk("nonmem_req", {dmem_read, dmem_write}, 0);
      dmem_resp  = (i == 1);
      dmem_rdata = 16'h7777;
      @(posedge clk); #1;
      dmem_resp = 0;
    end
    #1;
    chk("nonmem_load", load_data, exp_load);
    chk("nonmem_done", {31'b0, done}, 0);
    valid_in = 0;
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++) begin
      run_txn(ops[$urandom_range(0, 6)],
              16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom),
              $urandom_range(1, 4), $urandom_range(1, 4),
              1);
    end

    // reset during the second access of an LDI
    valid_in = 1; opcode = OP_LDI;
    mem_read_in = 0; mem_write_in = 0;
    address_in = 16'h4000;
    @(posedge clk); #1;
    dmem_resp = 1; dmem_rdata = 16'h5000;
    @(posedge clk); #1;
    dmem_resp = 0; dmem_rdata = 16'h1111;
    #1;
    chk("rst_acc_read", {31'b0, dmem_read}, 1);
    chk("rst_acc_addr", dmem_address, 16'h5000);
    valid_in = 0;
    reset = 1;
    #1;
    chk("rst_mid_read", {31'b0, dmem_read}, 0);
    chk("rst_mid_stall", {31'b0, stall}, 0);
    chk("rst_mid_load", load_data, 16'h0);
    @(posedge clk); #1;
    reset = 0;
    dmem_resp = 1; dmem_rdata = 16'h9999;
    @(posedge clk); #1;
    dmem_resp = 0;
    #1;
    chk("stray_load", load_data, 16'h0);
    chk("stray_done", {31'b0, done}, 0);
    chk("stray_req", {dmem_read, dmem_write}, 0);
    chk("stray_stall", {31'b0, stall}, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
